// File: rtl/tmds_pll_supervisor.sv
// Sequencing controller for the TMDS rPLL: pulses the PLL reset, qualifies LOCK,
// holds the video domain in reset until lock is stable and retries on lock loss.
module tmds_pll_supervisor #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 270000,
  parameter int STABLE_CYCLES = 2700,
  parameter int MAX_RETRY     = 4
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       pll_restart,
  output logic       pll_reset,
  output logic       video_rst,
  output logic       pll_ready,
  output logic       fail,
  output logic [7:0] relock_count,
  output logic [2:0] state
);

  localparam logic [2:0] S_RESET_PLL   = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK   = 3'd1;
  localparam logic [2:0] S_STABLE_WAIT = 3'd2;
  localparam logic [2:0] S_RUN         = 3'd3;
  localparam logic [2:0] S_FAIL        = 3'd4;

  localparam int RW  = $clog2(RST_CYCLES) + 1;
  localparam int TW  = $clog2(LOCK_TIMEOUT) + 1;
  localparam int SW  = $clog2(STABLE_CYCLES) + 1;
  localparam int RTW = $clog2(MAX_RETRY) + 1;

  localparam logic [RW-1:0]  RST_LAST    = RW'(RST_CYCLES - 1);
  localparam logic [TW-1:0]  TO_LAST     = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0]  STABLE_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [RTW-1:0] RETRY_MAX   = RTW'(MAX_RETRY);

  logic           lock_m;
  logic           lock_s;
  logic [RW-1:0]  rst_cnt;
  logic [TW-1:0]  to_cnt;
  logic [SW-1:0]  stable_cnt;
  logic [RTW-1:0] retry_cnt;
  logic [RTW-1:0] retry_inc;
  logic [2:0]     next_state;
  logic           attempt_fail;
  logic           restart_hit;
  logic           lock_lost;
  logic           run_entry;

  assign retry_inc = retry_cnt + RTW'(1);

  // Restart has priority over lock loss in RUN, so a coincident loss is not counted.
  always_comb begin
    next_state   = state;
    attempt_fail = 1'b0;
    restart_hit  = 1'b0;
    lock_lost    = 1'b0;
    run_entry    = 1'b0;
    case (state)
      S_RESET_PLL: begin
        if (rst_cnt == RST_LAST) next_state = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (pll_restart) begin
          restart_hit = 1'b1;
          next_state  = S_RESET_PLL;
        end else if (lock_s) begin
          next_state = S_STABLE_WAIT;
        end else if (to_cnt == TO_LAST) begin
          attempt_fail = 1'b1;
        end
      end
      S_STABLE_WAIT: begin
        if (pll_restart) begin
          restart_hit = 1'b1;
          next_state  = S_RESET_PLL;
        end else if (!lock_s) begin
          attempt_fail = 1'b1;
        end else if (stable_cnt == STABLE_LAST) begin
          run_entry  = 1'b1;
          next_state = S_RUN;
        end
      end
      S_RUN: begin
        if (pll_restart) begin
          restart_hit = 1'b1;
          next_state  = S_RESET_PLL;
        end else if (!lock_s) begin
          lock_lost  = 1'b1;
          next_state = S_RESET_PLL;
        end
      end
      S_FAIL: next_state = S_FAIL;
      default: next_state = S_RESET_PLL;
    endcase
    if (attempt_fail) next_state = (retry_inc == RETRY_MAX) ? S_FAIL : S_RESET_PLL;
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      lock_m       <= 1'b0;
      lock_s       <= 1'b0;
      state        <= S_RESET_PLL;
      rst_cnt      <= '0;
      to_cnt       <= '0;
      stable_cnt   <= '0;
      retry_cnt    <= '0;
      relock_count <= 8'd0;
      pll_reset    <= 1'b1;
      video_rst    <= 1'b1;
      pll_ready    <= 1'b0;
      fail         <= 1'b0;
    end else begin
      lock_m <= pll_lock;
      lock_s <= lock_m;
      state  <= next_state;
      // Each counter restarts from zero whenever its state is (re)entered.
      rst_cnt    <= (state == S_RESET_PLL && next_state == S_RESET_PLL) ? rst_cnt + RW'(1) : '0;
      to_cnt     <= (state == S_WAIT_LOCK && next_state == S_WAIT_LOCK) ? to_cnt + TW'(1) : '0;
      stable_cnt <= (state == S_STABLE_WAIT && next_state == S_STABLE_WAIT) ?
                    stable_cnt + SW'(1) : '0;
      if (restart_hit || run_entry) retry_cnt <= '0;
      else if (attempt_fail)        retry_cnt <= retry_inc;
      if (lock_lost && relock_count != 8'hff) relock_count <= relock_count + 8'd1;
      // Outputs are decoded from the next state so they change on the entry edge.
      pll_reset <= (next_state == S_RESET_PLL);
      video_rst <= (next_state != S_RUN);
      pll_ready <= (next_state == S_RUN);
      fail      <= fail | (next_state == S_FAIL);
    end
  end

endmodule

// File: tb/tb_tmds_pll_supervisor.sv
// Self-checking bench for tmds_pll_supervisor with short timing parameters;
// every expected output vector is queued as stimulus is driven and compared after the edge.
module tb_tmds_pll_supervisor;

  localparam int W = 15;
  localparam logic [2:0] S_RST  = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_STB  = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_FAIL = 3'd4;

  logic       clkin = 1'b0;
  logic       reset = 1'b1;
  logic       pll_lock = 1'b0;
  logic       pll_restart = 1'b0;
  logic       pll_reset;
  logic       video_rst;
  logic       pll_ready;
  logic       fail;
  logic [7:0] relock_count;
  logic [2:0] state;
  logic [W-1:0] dut_vec;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int checks = 0;
  int failures = 0;

  tmds_pll_supervisor #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(50), .STABLE_CYCLES(8), .MAX_RETRY(2)
  ) dut (
    .clkin(clkin), .reset(reset), .pll_lock(pll_lock), .pll_restart(pll_restart),
    .pll_reset(pll_reset), .video_rst(video_rst), .pll_ready(pll_ready), .fail(fail),
    .relock_count(relock_count), .state(state)
  );

  assign dut_vec = {state, pll_reset, video_rst, pll_ready, fail, relock_count};

  // clock / watchdog
  always #5 clkin = ~clkin;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  // Expected output vector for a state: {state, pll_reset, video_rst, pll_ready, fail, relock}
  function automatic logic [W-1:0] ev(input logic [2:0] st, input logic [7:0] rc);
    logic prst, vrst, rdy, fl;
    prst = (st == S_RST);
    vrst = (st != S_RUN);
    rdy  = (st == S_RUN);
    fl   = (st == S_FAIL);
    return {st, prst, vrst, rdy, fl, rc};
  endfunction

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got st=%0d prst=%b vrst=%b rdy=%b fail=%b relock=%0d, exp st=%0d prst=%b vrst=%b rdy=%b fail=%b relock=%0d",
               tag, got[14:12], got[11], got[10], got[9], got[8], got[7:0],
               exp[14:12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  // driver: one clock with given inputs; expectation queued, compared at the next negedge
  task automatic step(input logic lock, input logic restart, input logic [2:0] st,
                      input logic [7:0] rc, input string tag);
    pll_lock    = lock;
    pll_restart = restart;
    exp_q.push_back(ev(st, rc));
    tag_q.push_back(tag);
    @(posedge clkin);
    @(negedge clkin);
    pll_restart = 1'b0;
    check_eq(tag_q.pop_front(), dut_vec, exp_q.pop_front());
  endtask

  task automatic steps(input int n, input logic lock, input logic [2:0] st,
                       input logic [7:0] rc, input string tag);
    for (int i = 0; i < n; i++) step(lock, 1'b0, st, rc, tag);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    steps(n, 1'b0, S_RST, 8'd0, "reset_state");
    reset = 1'b0;
  endtask

  // RESET_PLL was entered on the previous edge: 3 more pulse edges, then WAIT_LOCK
  task automatic finish_pulse(input logic lock, input logic [7:0] rc);
    steps(3, lock, S_RST, rc, "pll_reset_pulse");
    step(lock, 1'b0, S_WAIT, rc, "wait_entry");
  endtask

  // WAIT_LOCK was just entered: 49 more waiting edges, then the timeout edge
  task automatic timeout_from_wait(input logic [2:0] after, input logic [7:0] rc);
    steps(49, 1'b0, S_WAIT, rc, "wait_no_lock");
    step(1'b0, 1'b0, after, rc, "timeout");
  endtask

  // In WAIT_LOCK with lock_s low: lock rises, RUN ten edges after the first sampling edge
  task automatic bring_up(input logic [7:0] rc);
    steps(2, 1'b1, S_WAIT, rc, "lock_sync");
    steps(8, 1'b1, S_STB, rc, "stable_wait");
    step(1'b1, 1'b0, S_RUN, rc, "run_entry");
  endtask

  // WAIT_LOCK just entered with lock_s already high
  task automatic relock_held(input logic [7:0] rc);
    steps(8, 1'b1, S_STB, rc, "stable_wait_held");
    step(1'b1, 1'b0, S_RUN, rc, "run_reentry");
  endtask

  // In RUN: lock low for 3 cycles, then back and a clean relock
  task automatic lose_and_relock(input logic [7:0] rc, input logic [7:0] nrc);
    steps(2, 1'b0, S_RUN, rc, "loss_sync");
    step(1'b0, 1'b0, S_RST, nrc, "loss_reset");
    finish_pulse(1'b1, nrc);
    relock_held(nrc);
  endtask

  initial begin
    logic [7:0] rc;
    logic [7:0] nrc;
    @(negedge clkin);

    // power-up, lock 10 cycles after release
    do_reset(3);
    finish_pulse(1'b0, 8'd0);
    steps(5, 1'b0, S_WAIT, 8'd0, "wait_before_lock");
    bring_up(8'd0);

    // 3-cycle lock drop in RUN
    lose_and_relock(8'd0, 8'd1);

    // lock never asserts: two timeouts then FAIL; lock and restart ignored
    do_reset(2);
    finish_pulse(1'b0, 8'd0);
    timeout_from_wait(S_RST, 8'd0);
    finish_pulse(1'b0, 8'd0);
    timeout_from_wait(S_FAIL, 8'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, S_FAIL, 8'd0, "fail_ignores_restart");
    steps(6, 1'b1, S_FAIL, 8'd0, "fail_ignores_lock");

    // glitch in STABLE_WAIT at stable count 5, good relock clears retry
    do_reset(2);
    finish_pulse(1'b0, 8'd0);
    steps(2, 1'b0, S_WAIT, 8'd0, "wait_before_lock");
    steps(2, 1'b1, S_WAIT, 8'd0, "lock_sync");
    steps(4, 1'b1, S_STB, 8'd0, "stable_wait");
    steps(2, 1'b0, S_STB, 8'd0, "stable_glitch_sync");
    step(1'b0, 1'b0, S_RST, 8'd0, "stable_abort");
    finish_pulse(1'b0, 8'd0);
    bring_up(8'd0);
    steps(2, 1'b0, S_RUN, 8'd0, "loss_sync");
    step(1'b0, 1'b0, S_RST, 8'd1, "loss_reset");
    finish_pulse(1'b0, 8'd1);
    timeout_from_wait(S_RST, 8'd1);
    finish_pulse(1'b0, 8'd1);
    timeout_from_wait(S_FAIL, 8'd1);

    // restart coincident with lock loss in RUN, then saturation of relock_count
    do_reset(2);
    finish_pulse(1'b0, 8'd0);
    bring_up(8'd0);
    step(1'b1, 1'b1, S_RST, 8'd0, "restart_in_run");
    finish_pulse(1'b1, 8'd0);
    relock_held(8'd0);
    steps(2, 1'b0, S_RUN, 8'd0, "loss_sync");
    step(1'b0, 1'b1, S_RST, 8'd0, "restart_with_loss");
    finish_pulse(1'b1, 8'd0);
    relock_held(8'd0);
    rc = 8'd0;
    for (int i = 0; i < 256; i++) begin
      nrc = (rc == 8'd255) ? 8'd255 : rc + 8'd1;
      lose_and_relock(rc, nrc);
      rc = nrc;
    end
    check_eq("relock_saturated", {7'd0, relock_count}, {7'd0, 8'd255});

    // reset while in FAIL with relock_count=3
    do_reset(2);
    finish_pulse(1'b0, 8'd0);
    bring_up(8'd0);
    lose_and_relock(8'd0, 8'd1);
    lose_and_relock(8'd1, 8'd2);
    steps(2, 1'b0, S_RUN, 8'd2, "loss_sync");
    step(1'b0, 1'b0, S_RST, 8'd3, "loss_reset");
    finish_pulse(1'b0, 8'd3);
    timeout_from_wait(S_RST, 8'd3);
    finish_pulse(1'b0, 8'd3);
    timeout_from_wait(S_FAIL, 8'd3);
    steps(3, 1'b0, S_FAIL, 8'd3, "fail_hold");
    reset = 1'b1;
    step(1'b0, 1'b0, S_RST, 8'd0, "reset_clears_fail");
    reset = 1'b0;
    finish_pulse(1'b0, 8'd0);

    // restart ignored in RESET_PLL, honoured in WAIT_LOCK/STABLE_WAIT, and clears retries
    do_reset(2);
    step(1'b0, 1'b1, S_RST, 8'd0, "restart_ignored_in_reset");
    steps(2, 1'b0, S_RST, 8'd0, "pll_reset_pulse");
    step(1'b0, 1'b0, S_WAIT, 8'd0, "wait_entry");
    timeout_from_wait(S_RST, 8'd0);
    finish_pulse(1'b0, 8'd0);
    steps(3, 1'b0, S_WAIT, 8'd0, "wait_before_restart");
    step(1'b0, 1'b1, S_RST, 8'd0, "restart_in_wait");
    finish_pulse(1'b0, 8'd0);
    timeout_from_wait(S_RST, 8'd0);
    finish_pulse(1'b0, 8'd0);
    steps(2, 1'b1, S_WAIT, 8'd0, "lock_sync");
    steps(3, 1'b1, S_STB, 8'd0, "stable_wait");
    step(1'b1, 1'b1, S_RST, 8'd0, "restart_in_stable");
    finish_pulse(1'b1, 8'd0);
    relock_held(8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
